// File: rtl/urv_dmem_wb_bridge.sv
// uRV execute-stage data-memory responder: one load/store per handshake as one Wishbone pipelined cycle.
// Optional bus watchdog (g_timeout cycles) is compiled in when URV_DMEM_TIMEOUT_EN is defined.
module urv_dmem_wb_bridge #(
   parameter int unsigned g_timeout = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic        dm_ready_o,
   output logic [31:0] dm_data_l_o,
   output logic        dm_load_done_o,
   output logic        dm_store_done_o,
   output logic        dm_bus_error_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_stall_i
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   if (g_timeout < 2 || g_timeout > 65535) begin : g_bad_timeout
      $error("urv_dmem_wb_bridge: g_timeout must be in 2..65535");
   end

   state_t state_q;
   state_t state_d;
   logic   accept;
   logic   bus_ack;
   logic   bus_err;
   logic   timeout_hit;
   logic   complete;
   logic   cmp_err;

   // Bus responses only count once the strobe has actually been taken (stall low) or in WAIT_ACK.
   always_comb begin
      // NOTE: every always_comb output is given a default first so no latch is inferred.
      accept  = 1'b0;
      bus_ack = 1'b0;
      bus_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            accept = dm_load_i | dm_store_i;
         end
         ST_REQ: begin
            bus_ack = wb_ack_i & ~wb_stall_i;
            bus_err = wb_err_i & ~wb_stall_i;
         end
         ST_WAIT_ACK: begin
            bus_ack = wb_ack_i;
            bus_err = wb_err_i;
         end
         default: ;
      endcase
   end

`ifdef URV_DMEM_TIMEOUT_EN
   localparam logic [15:0] tmo_last = 16'(g_timeout - 1);

   logic [15:0] tmo_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         tmo_cnt_q <= '0;
      else if (accept)
         tmo_cnt_q <= '0;
      else if (state_q != ST_IDLE)
         tmo_cnt_q <= tmo_cnt_q + 16'd1;
   end

   // A real ack or err in the expiry cycle wins over the watchdog.
   assign timeout_hit = (state_q != ST_IDLE) && (tmo_cnt_q == tmo_last) && !bus_ack && !bus_err;
`else
   assign timeout_hit = 1'b0;
`endif

   assign complete = bus_ack | bus_err | timeout_hit;
   assign cmp_err  = bus_err | timeout_hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (accept) state_d = ST_REQ;
         ST_REQ:      if (!wb_stall_i) state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: state_d = ST_WAIT_ACK;
         default:     state_d = ST_IDLE;
      endcase
      if (complete)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst_i)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   assign dm_ready_o = (state_q == ST_IDLE);
   assign wb_cyc_o   = (state_q != ST_IDLE);
   assign wb_stb_o   = (state_q == ST_REQ);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_we_o         <= 1'b0;
         wb_adr_o        <= '0;
         wb_sel_o        <= '0;
         wb_dat_o        <= '0;
         dm_data_l_o     <= '0;
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         dm_bus_error_o  <= 1'b0;
      end else begin
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         dm_bus_error_o  <= 1'b0;

         if (accept) begin
            // A simultaneous load+store request is performed as the store.
            wb_we_o  <= dm_store_i;
            wb_adr_o <= {dm_addr_i[31:2], 2'b00};
            wb_sel_o <= dm_store_i ? dm_data_select_i : 4'b1111;
            wb_dat_o <= dm_data_s_i;
         end

         if (complete) begin
            dm_bus_error_o <= cmp_err;
            if (wb_we_o) begin
               dm_store_done_o <= 1'b1;
            end else begin
               dm_load_done_o <= 1'b1;
               dm_data_l_o    <= cmp_err ? 32'h0 : wb_dat_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_urv_dmem_wb_bridge.sv
// Self-checking bench for urv_dmem_wb_bridge: directed vector table, corner sequences,
// and randomized transfers scored against a transaction-level model.
module tb_urv_dmem_wb_bridge;

`ifdef URV_DMEM_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 1024;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_data_s_i;
   logic [3:0]  dm_data_select_i;
   logic        dm_store_i;
   logic        dm_load_i;
   logic        dm_ready_o;
   logic [31:0] dm_data_l_o;
   logic        dm_load_done_o;
   logic        dm_store_done_o;
   logic        dm_bus_error_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        wb_stall_i;

   urv_dmem_wb_bridge #(.g_timeout(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
      .dm_store_i(dm_store_i), .dm_load_i(dm_load_i), .dm_ready_o(dm_ready_o),
      .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
      .dm_store_done_o(dm_store_done_o), .dm_bus_error_o(dm_bus_error_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
   );

   always #5 clk_i = ~clk_i;

   int cycle_no = 0;
   always @(posedge clk_i) cycle_no <= cycle_no + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // resp: 0 = ack, 1 = err, 2 = ack and err together
   typedef struct {
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      int          nstall;
      int          nwait;
      int          resp;
      logic [31:0] rdata;
      logic [31:0] e_adr;
      logic [3:0]  e_sel;
      logic        e_we;
      int          e_lat;
      logic        e_ldone;
      logic        e_sdone;
      logic        e_err;
      logic [31:0] e_data;
   } vec_t;

   function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] sel, input int ns,
                               input int nw, input int rsp, input logic [31:0] rd,
                               input logic [31:0] ea, input logic [3:0] es, input logic ew,
                               input int el, input logic eld, input logic esd, input logic eer,
                               input logic [31:0] ed);
      vec_t v;
      v.ld = ld; v.st = st; v.addr = addr; v.data = data; v.sel = sel;
      v.nstall = ns; v.nwait = nw; v.resp = rsp; v.rdata = rd;
      v.e_adr = ea; v.e_sel = es; v.e_we = ew; v.e_lat = el;
      v.e_ldone = eld; v.e_sdone = esd; v.e_err = eer; v.e_data = ed;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_bus();
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_stall_i = 1'b0;
   endtask

   // Drives one request from an idle cycle and plays the slave side from the vector's plan.
   task automatic run_txn(input vec_t v, input string tag);
      int low;
      int stbs;
      int stray;
      bit done;
      check({tag, ".ready_in"}, 32'(dm_ready_o), 32'd1);
      dm_load_i = v.ld; dm_store_i = v.st; dm_addr_i = v.addr;
      dm_data_s_i = v.data; dm_data_select_i = v.sel;
      idle_bus();
      low = 0; stbs = 0; stray = 0; done = 0;
      for (int k = 1; k <= 64 && !done; k++) begin
         step();
         if (k == 1) begin
            dm_load_i = 1'b0; dm_store_i = 1'b0;
            dm_addr_i = $urandom; dm_data_s_i = $urandom; dm_data_select_i = 4'($urandom);
         end
         if (dm_ready_o) begin
            done = 1;
            idle_bus();
            check({tag, ".load_done"},  32'(dm_load_done_o),  32'(v.e_ldone));
            check({tag, ".store_done"}, 32'(dm_store_done_o), 32'(v.e_sdone));
            check({tag, ".bus_error"},  32'(dm_bus_error_o),  32'(v.e_err));
            check({tag, ".load_data"},  dm_data_l_o,          v.e_data);
            check({tag, ".cyc_end"},    32'(wb_cyc_o),        32'd0);
         end else begin
            low++;
            if (wb_stb_o) stbs++;
            if (dm_load_done_o || dm_store_done_o || dm_bus_error_o || !wb_cyc_o) stray++;
            if (k == 1) begin
               check({tag, ".adr"}, wb_adr_o,        v.e_adr);
               check({tag, ".sel"}, 32'(wb_sel_o),   32'(v.e_sel));
               check({tag, ".we"},  32'(wb_we_o),    32'(v.e_we));
               if (v.e_we) check({tag, ".dat"}, wb_dat_o, v.data);
            end
            wb_stall_i = (k <= v.nstall);
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
            if (k <= v.nstall) begin
               wb_ack_i = 1'($urandom_range(0, 1));
               wb_err_i = 1'($urandom_range(0, 1));
            end else if (k == v.nstall + 1 + v.nwait) begin
               wb_ack_i = (v.resp != 1);
               wb_err_i = (v.resp != 0);
               wb_dat_i = v.rdata;
            end
         end
      end
      check({tag, ".completed"}, 32'(done), 32'd1);
      check({tag, ".ready_low_cycles"}, 32'(low), 32'(v.e_lat));
      check({tag, ".stb_cycles"}, 32'(stbs), 32'(v.nstall + 1));
      check({tag, ".stray_in_flight"}, 32'(stray), 32'd0);
   endtask

   vec_t tbl[6];
   vec_t rv;
   logic [31:0] model_data;
   int t_stb1, t_stb2, cyc_cnt, r;
   bit seen;

   initial begin
      // Directed vectors; expected load data follows the table order.
      tbl[0] = mk(1, 0, 32'h0000_1006, 32'h0,         4'h0, 0, 1, 0, 32'hCAFE_BABE,
                  32'h0000_1004, 4'hF, 0, 2, 1, 0, 0, 32'hCAFE_BABE);
      tbl[1] = mk(0, 1, 32'h2000_0012, 32'h1111_1111, 4'b0100, 3, 2, 0, 32'h0,
                  32'h2000_0010, 4'b0100, 1, 6, 0, 1, 0, 32'hCAFE_BABE);
      tbl[2] = mk(1, 0, 32'h3000_0003, 32'h0,         4'h0, 0, 0, 2, 32'hDEAD_BEEF,
                  32'h3000_0000, 4'hF, 0, 1, 1, 0, 1, 32'h0);
      tbl[3] = mk(1, 1, 32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 1, 0, 0, 32'h1234_5678,
                  32'h0000_0040, 4'b0011, 1, 2, 0, 1, 0, 32'h0);
      tbl[4] = mk(0, 1, 32'h5000_0007, 32'h89AB_CDEF, 4'b1000, 0, 3, 1, 32'h0,
                  32'h5000_0004, 4'b1000, 1, 4, 0, 1, 1, 32'h0);
      tbl[5] = mk(1, 0, 32'hFFFF_FFFF, 32'h0,         4'h0, 2, 0, 0, 32'h0BAD_F00D,
                  32'hFFFF_FFFC, 4'hF, 0, 3, 1, 0, 0, 32'h0BAD_F00D);

      rst_i = 1'b1;
      dm_addr_i = '0; dm_data_s_i = '0; dm_data_select_i = '0;
      dm_load_i = 1'b0; dm_store_i = 1'b0; wb_dat_i = '0;
      idle_bus();
      repeat (3) step();
      rst_i = 1'b0;
      check("rst.ready",      32'(dm_ready_o),      32'd1);
      check("rst.cyc",        32'(wb_cyc_o),        32'd0);
      check("rst.stb",        32'(wb_stb_o),        32'd0);
      check("rst.we",         32'(wb_we_o),         32'd0);
      check("rst.pulses",     32'({dm_load_done_o, dm_store_done_o, dm_bus_error_o}), 32'd0);
      check("rst.load_data",  dm_data_l_o,          32'h0);
      check("rst.adr",        wb_adr_o,             32'h0);
      check("rst.sel",        32'(wb_sel_o),        32'h0);
      check("rst.dat",        wb_dat_o,             32'h0);
      step();

      for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Spurious responses while idle must be ignored.
      wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFF_0000;
      for (int i = 0; i < 2; i++) begin
         step();
         check("idle_spurious.pulses", 32'({dm_load_done_o, dm_store_done_o, dm_bus_error_o}), 32'd0);
         check("idle_spurious.cyc", 32'(wb_cyc_o), 32'd0);
      end
      idle_bus();
      check("idle_spurious.data_held", dm_data_l_o, 32'h0BAD_F00D);

      // Back-to-back load then store with a zero-wait slave.
      dm_load_i = 1'b1; dm_addr_i = 32'h0000_0100;
      step();
      dm_load_i = 1'b0;
      t_stb1 = cycle_no;
      check("b2b.stb1", 32'(wb_stb_o), 32'd1);
      check("b2b.we1",  32'(wb_we_o),  32'd0);
      wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA;
      step();
      check("b2b.load_done", 32'(dm_load_done_o), 32'd1);
      check("b2b.load_data", dm_data_l_o, 32'h55AA_55AA);
      check("b2b.ready_mid", 32'(dm_ready_o), 32'd1);
      wb_ack_i = 1'b0;
      dm_store_i = 1'b1; dm_addr_i = 32'h0000_0104; dm_data_s_i = 32'h7777_7777; dm_data_select_i = 4'hF;
      step();
      dm_store_i = 1'b0;
      t_stb2 = cycle_no;
      check("b2b.stb2", 32'(wb_stb_o), 32'd1);
      check("b2b.we2",  32'(wb_we_o),  32'd1);
      check("b2b.stb_spacing", 32'(t_stb2 - t_stb1), 32'd2);
      check("b2b.no_second_load_done", 32'(dm_load_done_o), 32'd0);
      wb_ack_i = 1'b1;
      step();
      idle_bus();
      check("b2b.store_done", 32'(dm_store_done_o), 32'd1);
      check("b2b.load_done_off", 32'(dm_load_done_o), 32'd0);
      check("b2b.ready_end", 32'(dm_ready_o), 32'd1);
      step();

`ifdef URV_DMEM_TIMEOUT_EN
      // Silent slave: the watchdog ends the cycle as an error after TO cycles.
      dm_load_i = 1'b1; dm_addr_i = 32'h6000_0000;
      cyc_cnt = 0; seen = 0;
      for (int k = 1; k <= 64 && !seen; k++) begin
         step();
         dm_load_i = 1'b0;
         wb_stall_i = (k <= 3);
         if (wb_cyc_o) cyc_cnt++;
         else seen = 1;
      end
      idle_bus();
      check("tmo.ended", 32'(seen), 32'd1);
      check("tmo.cyc_cycles", 32'(cyc_cnt), 32'(TO));
      check("tmo.load_done", 32'(dm_load_done_o), 32'd1);
      check("tmo.bus_error", 32'(dm_bus_error_o), 32'd1);
      check("tmo.load_data", dm_data_l_o, 32'h0);
      run_txn(mk(0, 1, 32'h6000_0008, 32'h0F0F_0F0F, 4'b0001, 1, 1, 0, 32'h0,
                 32'h6000_0008, 4'b0001, 1, 3, 0, 1, 0, 32'h0), "tmo_next");
`endif

      // Reset while waiting for ack; a late ack must not complete anything.
      dm_load_i = 1'b1; dm_addr_i = 32'h0000_0700;
      step();
      dm_load_i = 1'b0;
      step();
      check("rstmid.wait_cyc", 32'(wb_cyc_o), 32'd1);
      check("rstmid.wait_stb", 32'(wb_stb_o), 32'd0);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("rstmid.cyc",    32'(wb_cyc_o),   32'd0);
      check("rstmid.stb",    32'(wb_stb_o),   32'd0);
      check("rstmid.ready",  32'(dm_ready_o), 32'd1);
      check("rstmid.pulses", 32'({dm_load_done_o, dm_store_done_o, dm_bus_error_o}), 32'd0);
      wb_ack_i = 1'b1; wb_dat_i = 32'h1234_0000;
      step();
      idle_bus();
      check("rstmid.late_ack_pulses", 32'({dm_load_done_o, dm_store_done_o, dm_bus_error_o}), 32'd0);
      check("rstmid.late_ack_ready", 32'(dm_ready_o), 32'd1);
      check("rstmid.load_data", dm_data_l_o, 32'h0);

      // Randomized transfers scored against a transaction-level model.
      model_data = 32'h0;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 3);
         rv.ld     = (r != 1);
         rv.st     = (r == 1) || (r == 2);
         rv.addr   = $urandom;
         rv.data   = $urandom;
         rv.sel    = 4'($urandom);
         rv.nstall = $urandom_range(0, 3);
         rv.nwait  = $urandom_range(0, 3);
         r = $urandom_range(0, 4);
         rv.resp   = (r <= 2) ? 0 : (r == 3) ? 1 : 2;
         rv.rdata  = $urandom;
         rv.e_adr  = rv.addr - (rv.addr % 4);
         rv.e_sel  = rv.st ? rv.sel : 4'hF;
         rv.e_we   = rv.st;
         rv.e_lat  = rv.nstall + 1 + rv.nwait;
         rv.e_ldone = rv.ld && !rv.st;
         rv.e_sdone = rv.st;
         rv.e_err  = (rv.resp != 0);
         if (rv.e_ldone) model_data = rv.e_err ? 32'h0 : rv.rdata;
         rv.e_data = model_data;
         run_txn(rv, $sformatf("rnd%0d", i));
      end

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/urv_dmem_wb_bridge.md
Name: urv_dmem_wb_bridge

Overview:
Responder end of the uRV execute-stage data-memory interface. It accepts one load or store per handshake from the core's dm_* port and performs it as a single Wishbone pipelined-master cycle. It returns the load data and completion strobes to the writeback stage. It holds dm_ready_o low while a transfer is outstanding, which stalls the execute stage.

Parameters:
g_timeout, 1024, bus watchdog limit in clock cycles (used only when URV_DMEM_TIMEOUT_EN is defined); range 2..65535.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
dm_addr_i  in  32  byte address from the execute stage
dm_data_s_i  in  32  store data, already lane-replicated
dm_data_select_i  in  4  byte-lane select for stores
dm_store_i  in  1  store request strobe
dm_load_i  in  1  load request strobe
dm_ready_o  out  1  bridge idle; a request is accepted only while this is 1
dm_data_l_o  out  32  raw load word; valid while dm_load_done_o=1 and held until the next load completes
dm_load_done_o  out  1  one-cycle pulse when a load completes
dm_store_done_o  out  1  one-cycle pulse when a store completes
dm_bus_error_o  out  1  one-cycle pulse, coincident with done, when the transfer ended in error
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  32  word address {addr[31:2],2'b00}
wb_sel_o  out  4  Wishbone byte select
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
wb_stall_i  in  1  Wishbone pipeline stall

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - dm_ready_o=1
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0
  - all done and error pulses 0
  - dm_data_l_o=0
  - wb_adr_o, wb_sel_o and wb_dat_o = 0
- FSM states: IDLE, REQ, WAIT_ACK.
- IDLE:
  - dm_ready_o=1.
  - When dm_load_i|dm_store_i: register address, select, data and we (we=dm_store_i); set cyc=stb=1; go to REQ. dm_ready_o drops on the next edge.
  - For loads, wb_sel_o=4'b1111. For stores, wb_sel_o=dm_data_select_i.
  - If dm_load_i and dm_store_i are both 1: the store is performed and no load_done is generated.
- REQ:
  - cyc=stb=1.
  - When wb_stall_i=0: stb drops next edge and the FSM goes to WAIT_ACK.
  - If wb_ack_i or wb_err_i is also seen in this cycle while stall=0: complete immediately (see completion).
  - ack or err seen while wb_stall_i=1 is ignored.
- WAIT_ACK:
  - cyc=1, stb=0.
  - On wb_ack_i or wb_err_i: complete.
- Completion (registered; takes effect on the next edge):
  - cyc=0; return to IDLE; dm_ready_o=1.
  - Pulse dm_load_done_o or dm_store_done_o according to we.
  - Load + ack: dm_data_l_o=wb_dat_i.
  - Load + err: dm_data_l_o=0 and dm_bus_error_o pulses.
  - err has priority over a simultaneous ack.
- Minimum latency, zero-wait slave (acks in the first stb cycle): request accepted at edge 0; stb visible in cycle 1; done pulse and ready=1 in cycle 2. One transfer per 2 cycles sustained.
- Spurious ack or err in IDLE is ignored, with no pulses.
- Request strobes arriving while dm_ready_o=0 are ignored. The core gates them with its stall, so this does not occur legally.
- Reset mid-transfer: cyc and stb are deasserted at that edge, no done or error pulse is generated, and the FSM returns to IDLE.
- No byte extraction or sign extension; the writeback stage does that using the stored address.

Optional Feature:
URV_DMEM_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on acceptance and increments each cycle in REQ or WAIT_ACK.
  - When the count reaches g_timeout-1 with no ack or err, the transfer completes as an error: cyc=0, done and dm_bus_error_o pulse, load data=0.
  - An ack arriving in that same cycle wins, and no error is flagged.
- Undefined: no counter; the bridge waits indefinitely for ack or err.

Test Plan:
- Load 0x0000_1006, slave acks the cycle after stb with 0xCAFE_BABE -> wb_adr_o=0x0000_1004, sel=4'hF, we=0; dm_load_done_o pulses with dm_data_l_o=0xCAFE_BABE; dm_ready_o low for exactly 2 cycles.
- Store data 0x1111_1111, sel=4'b0100, wb_stall_i high 3 cycles then ack 2 cycles later -> stb held 4 cycles; one dm_store_done_o pulse; no load_done; ready restored the cycle after ack.
- Load answered with wb_err_i=1 and wb_ack_i=1 together -> dm_bus_error_o and dm_load_done_o pulse together; dm_data_l_o=0.
- With URV_DMEM_TIMEOUT_EN and g_timeout=8, slave never acks -> cyc drops after 8 cycles; error and done pulse; the next request is accepted normally.
- rst_i asserted in WAIT_ACK, followed by an ack on the next cycle -> cyc=0 after the reset edge; no done or error pulses; dm_ready_o=1.
- Back-to-back load then store, zero-wait slave -> second stb appears 2 cycles after the first; pulses in order load_done then store_done.
